// File: rtl/mhp_tx.sv
`default_nettype none
// ============================================================================
// Module   : mhp_tx
// Purpose  : MHP transmit frame builder. Serialises one frame onto a byte
//            valid/ready write interface in the order
//            dst[15:8] dst[7:0] src[15:8] src[7:0] size[15:8] size[7:0]
//            dtype payload... csum[15:8] csum[7:0].
//            The checksum is the modulo-2^16 sum of the header and payload
//            bytes.
// Ports    : i_clk/i_rst          clock, asynchronous active-low reset
//            i_start, i_dst, i_src, i_size, i_dtype
//                                 frame request and header fields
//            o_busy, o_done, o_err, o_csum
//                                 frame status and running checksum
//            i_pdata/i_pvalid/o_pready
//                                 payload byte stream (sink side)
//            o_wdata/o_wvalid/i_wready
//                                 Ethernet byte stream (source side)
// Revision : 1.0 - initial release
// ============================================================================
module mhp_tx #(
    parameter int MAX_SIZE = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_dst,
    input  logic [15:0] i_src,
    input  logic [15:0] i_size,
    input  logic [7:0]  i_dtype,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_csum,
    input  logic [7:0]  i_pdata,
    input  logic        i_pvalid,
    output logic        o_pready,
    output logic [7:0]  o_wdata,
    output logic        o_wvalid,
    input  logic        i_wready
);

    localparam logic [15:0] c_MAX_SIZE = 16'(MAX_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_dst;
    logic [15:0] r_src;
    logic [15:0] r_size;
    logic [7:0]  r_dtype;
    logic [2:0]  r_idx;      // header byte index 0..6
    logic [15:0] r_rem;      // payload bytes still to pull
    logic        r_cs_lo;    // high checksum byte already loaded
    logic [15:0] r_csum;
    logic [7:0]  r_wdata;
    logic        r_wvalid;
    logic        r_done;
    logic        r_err;

    logic        w_load_ok;
    logic        w_load;
    logic        w_add;
    logic [7:0]  w_byte;
    logic [7:0]  w_hdr_byte;
    logic        w_pready;
    logic        w_accept;
    logic        w_reject;
    logic        w_done;
    logic        w_hdr_last;

    // The output register may take a new byte when empty or being drained.
    assign w_load_ok = !r_wvalid || i_wready;

    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_idx)
            3'd0:    w_hdr_byte = r_dst[15:8];
            3'd1:    w_hdr_byte = r_dst[7:0];
            3'd2:    w_hdr_byte = r_src[15:8];
            3'd3:    w_hdr_byte = r_src[7:0];
            3'd4:    w_hdr_byte = r_size[15:8];
            3'd5:    w_hdr_byte = r_size[7:0];
            3'd6:    w_hdr_byte = r_dtype;
            default: w_hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_add       = 1'b0;
        w_byte      = 8'h00;
        w_pready    = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_done      = 1'b0;
        w_hdr_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_size > c_MAX_SIZE) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (w_load_ok) begin
                    w_load = 1'b1;
                    w_add  = 1'b1;
                    w_byte = w_hdr_byte;
                    if (r_idx == 3'd6) begin
                        w_hdr_last  = 1'b1;
                        w_state_nxt = (r_size == 16'd0) ? ST_CSUM : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                // Ready depends combinationally on i_wready so a byte can
                // stream through every cycle without a bubble.
                w_pready = w_load_ok && (r_rem != 16'd0);
                if (w_pready && i_pvalid) begin
                    w_load = 1'b1;
                    w_add  = 1'b1;
                    w_byte = i_pdata;
                    if (r_rem == 16'd1) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_load_ok) begin
                    w_load = 1'b1;
                    w_byte = r_cs_lo ? r_csum[7:0] : r_csum[15:8];
                    if (r_cs_lo) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_wvalid && i_wready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_dst    <= 16'h0000;
            r_src    <= 16'h0000;
            r_size   <= 16'h0000;
            r_dtype  <= 8'h00;
            r_idx    <= 3'd0;
            r_rem    <= 16'h0000;
            r_cs_lo  <= 1'b0;
            r_csum   <= 16'h0000;
            r_wdata  <= 8'h00;
            r_wvalid <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_done;
            r_err  <= w_reject;

            if (w_accept) begin
                r_dst   <= i_dst;
                r_src   <= i_src;
                r_size  <= i_size;
                r_dtype <= i_dtype;
                r_idx   <= 3'd0;
                r_cs_lo <= 1'b0;
                r_csum  <= 16'h0000;
            end else if (w_add) begin
                r_csum <= r_csum + {8'h00, w_byte};
            end

            if (r_state == ST_HDR && w_load) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_hdr_last) begin
                r_rem <= r_size;
            end else if (r_state == ST_PAYLOAD && w_load) begin
                r_rem <= r_rem - 16'd1;
            end
            if (r_state == ST_CSUM && w_load) begin
                r_cs_lo <= 1'b1;
            end

            // Register empties on its own when nothing new is loaded.
            if (w_load_ok) begin
                r_wvalid <= w_load;
                if (w_load) begin
                    r_wdata <= w_byte;
                end
            end
        end
    end

    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_csum   = r_csum;
    assign o_pready = w_pready;
    assign o_wdata  = r_wdata;
    assign o_wvalid = r_wvalid;

endmodule
`default_nettype wire

// File: tb/tb_mhp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mhp_tx
// Purpose  : Self-checking bench for mhp_tx. Expected frames are built from
//            the field values and payload list; the checksum is a plain
//            integer sum of the header and payload bytes taken mod 65536.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mhp_tx;

    localparam int MAXS   = 512;
    localparam int BUDGET = 6000;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_dst, i_src, i_size;
    logic [7:0]  i_dtype;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_csum;
    logic [7:0]  i_pdata;
    logic        i_pvalid, o_pready;
    logic [7:0]  o_wdata;
    logic        o_wvalid, i_wready;

    mhp_tx #(.MAX_SIZE(MAXS)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_dst   (i_dst),
        .i_src   (i_src),
        .i_size  (i_size),
        .i_dtype (i_dtype),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err),
        .o_csum  (o_csum),
        .i_pdata (i_pdata),
        .i_pvalid(i_pvalid),
        .o_pready(o_pready),
        .o_wdata (o_wdata),
        .o_wvalid(o_wvalid),
        .i_wready(i_wready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    typedef struct {
        logic [15:0] dst;
        logic [15:0] src;
        logic [15:0] size;
        logic [7:0]  dtype;
        int          pkind;     // 0: alternating p0/p1, 1: random
        logic [7:0]  p0;
        logic [7:0]  p1;
        int          bp;        // random i_wready / i_pvalid throttling
        int          gap;       // 5-cycle i_pvalid gap after first byte
        bit          has_csum;  // exp_csum is a hand-computed constant
        logic [15:0] exp_csum;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build_payload(input int kind, input logic [7:0] p0,
                                 input logic [7:0] p1, input int size);
        pay_q.delete();
        for (int i = 0; i < size; i++) begin
            if (kind == 0) pay_q.push_back((i % 2 == 0) ? p0 : p1);
            else           pay_q.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    // Reference frame: byte list and modulo-2^16 checksum.
    function automatic int model(input logic [15:0] dst, input logic [15:0] src,
                                 input logic [15:0] size, input logic [7:0] dtype);
        int sum;
        exp_q.delete();
        exp_q.push_back(dst[15:8]);  exp_q.push_back(dst[7:0]);
        exp_q.push_back(src[15:8]);  exp_q.push_back(src[7:0]);
        exp_q.push_back(size[15:8]); exp_q.push_back(size[7:0]);
        exp_q.push_back(dtype);
        foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
        sum = 0;
        foreach (exp_q[i]) sum += int'(exp_q[i]);
        sum = sum % 65536;
        exp_q.push_back(8'(sum >> 8));
        exp_q.push_back(8'(sum));
        return sum;
    endfunction

    task automatic run_frame(input logic [15:0] dst, input logic [15:0] src,
                             input logic [15:0] size, input logic [7:0] dtype,
                             input int bp, input int gap, input int inj_cyc,
                             input bit abort3,
                             output int n_done, output int n_hs,
                             output bit hold_ok, output bit timed_out);
        int         pidx;
        int         gap_left;
        int         cyc;
        bit         stall;
        bit         fin;
        logic [7:0] held;
        got_q.delete();
        n_done = 0; n_hs = 0; hold_ok = 1'b1; timed_out = 1'b0;
        pidx = 0; gap_left = gap ? 5 : 0; cyc = 0; stall = 1'b0; fin = 1'b0;
        held = 8'h00;
        @(posedge clk); #1;
        i_start = 1'b1; i_dst = dst; i_src = src; i_size = size; i_dtype = dtype;
        i_pvalid = 1'b0;
        i_wready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_dst = 16'($urandom); i_src = 16'($urandom);
        i_size = 16'($urandom); i_dtype = 8'($urandom);
        while (!fin) begin
            @(negedge clk);
            if (cyc == 0 && !abort3) check("busy_after_start", int'(o_busy), 1);
            if (stall && !(o_wvalid && o_wdata == held)) hold_ok = 1'b0;
            stall = o_wvalid && !i_wready;
            held  = o_wdata;
            if (o_wvalid && i_wready) got_q.push_back(o_wdata);
            if (i_pvalid && o_pready) begin
                pidx++;
                n_hs++;
            end
            if (o_done) begin
                n_done++;
                fin = 1'b1;
            end
            if (abort3 && n_hs == 3) begin
                i_rst = 1'b0;
                #1;
                check("abort_wvalid", int'(o_wvalid), 0);
                check("abort_busy", int'(o_busy), 0);
                fin = 1'b1;
            end
            cyc++;
            if (cyc > BUDGET) begin
                timed_out = 1'b1;
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                if (cyc == inj_cyc) begin
                    i_start = 1'b1;
                    i_dst = ~dst; i_src = ~src; i_size = 16'd1; i_dtype = ~dtype;
                end else begin
                    i_start = 1'b0;
                end
                i_wready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (gap != 0 && pidx == 1 && gap_left > 0) begin
                    i_pvalid = 1'b0;
                    gap_left--;
                end else begin
                    i_pvalid = (pidx < pay_q.size()) &&
                               (bp ? ($urandom_range(0, 4) != 0) : 1'b1);
                end
                i_pdata = (pidx < pay_q.size()) ? pay_q[pidx] : 8'($urandom);
            end
        end
        i_pvalid = 1'b0;
        i_start  = 1'b0;
    endtask

    task automatic check_frame(input string name, input int size, input int exp_csum,
                               input int n_done, input int n_hs,
                               input bit hold_ok, input bit timed_out);
        int bad;
        bad = -1;
        check({name, "_timeout"}, int'(timed_out), 0);
        check({name, "_done"}, n_done, 1);
        check({name, "_pay_hs"}, n_hs, size);
        check({name, "_nbytes"}, got_q.size(), 9 + size);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        end
        if (bad >= 0)
            check({name, "_byte_at_index"}, bad, -1);
        else
            check({name, "_bytes"}, 0, 0 * got_q.size());
        check({name, "_csum"}, int'(o_csum), exp_csum);
        check({name, "_hold"}, int'(hold_ok), 1);
    endtask

    // Watch an idle interface for n cycles; counts err/done pulses, any valid/busy.
    task automatic watch_idle(input int n, output int n_errp, output int n_donep,
                              output int n_wv, output int n_busy);
        n_errp = 0; n_donep = 0; n_wv = 0; n_busy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_err)    n_errp++;
            if (o_done)   n_donep++;
            if (o_wvalid) n_wv++;
            if (o_busy)   n_busy++;
            if (i == 0) begin
                @(posedge clk); #1;
                i_start = 1'b0;
            end
        end
    endtask

    vec_t vecs[5];

    initial begin
        int nd, nh, ne, nw, nb, exp_cs;
        bit hk, to;
        logic [15:0] rs;

        vecs[0] = '{16'h0010, 16'h0000, 16'd0,   8'h83, 0, 8'h00, 8'h00, 0, 0, 1'b1, 16'h0093};
        vecs[1] = '{16'h1234, 16'h0001, 16'd2,   8'h01, 0, 8'hAA, 8'h55, 0, 0, 1'b1, 16'h0149};
        vecs[2] = '{16'h1234, 16'h0001, 16'd2,   8'h01, 0, 8'hAA, 8'h55, 1, 1, 1'b1, 16'h0149};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'd512, 8'hFF, 0, 8'hFF, 8'hFF, 0, 0, 1'b1, 16'h02FD};
        vecs[4] = '{16'hBEEF, 16'hCAFE, 16'd7,   8'h42, 0, 8'h01, 8'h80, 1, 1, 1'b0, 16'h0000};

        i_rst = 1'b0; i_start = 1'b0; i_dst = '0; i_src = '0; i_size = '0;
        i_dtype = '0; i_pdata = '0; i_pvalid = 1'b0; i_wready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wvalid", int'(o_wvalid), 0);
        check("rst_wdata", int'(o_wdata), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_err", int'(o_err), 0);
        check("rst_csum", int'(o_csum), 0);
        i_pvalid = 1'b1;
        #1;
        check("rst_pready", int'(o_pready), 0);
        i_pvalid = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames, issued back to back.
        foreach (vecs[k]) begin
            build_payload(vecs[k].pkind, vecs[k].p0, vecs[k].p1, int'(vecs[k].size));
            exp_cs = model(vecs[k].dst, vecs[k].src, vecs[k].size, vecs[k].dtype);
            if (vecs[k].has_csum) exp_cs = int'(vecs[k].exp_csum);
            run_frame(vecs[k].dst, vecs[k].src, vecs[k].size, vecs[k].dtype,
                      vecs[k].bp, vecs[k].gap, -1, 1'b0, nd, nh, hk, to);
            check_frame($sformatf("vec%0d", k), int'(vecs[k].size), exp_cs, nd, nh, hk, to);
        end

        // Random frames against the model.
        for (int r = 0; r < 8; r++) begin
            rs = 16'($urandom_range(0, 24));
            build_payload(1, 8'h00, 8'h00, int'(rs));
            exp_cs = model(16'($urandom), 16'($urandom), rs, 8'($urandom));
            run_frame({exp_q[0], exp_q[1]}, {exp_q[2], exp_q[3]}, rs, exp_q[6],
                      int'(r % 2), int'(rs > 1 && r % 3 == 0), -1, 1'b0, nd, nh, hk, to);
            check_frame($sformatf("rnd%0d", r), int'(rs), exp_cs, nd, nh, hk, to);
        end

        // Oversize start is rejected.
        @(posedge clk); #1;
        i_start = 1'b1; i_size = 16'(MAXS + 1); i_dst = 16'h1111;
        watch_idle(12, ne, nd, nw, nb);
        check("oversize_err_pulses", ne, 1);
        check("oversize_wvalid", nw, 0);
        check("oversize_busy", nb, 0);

        // Reset after three payload bytes, then a clean empty frame.
        build_payload(0, 8'h11, 8'h22, 10);
        exp_cs = model(16'h0A0B, 16'h0C0D, 16'd10, 8'h05);
        run_frame(16'h0A0B, 16'h0C0D, 16'd10, 8'h05, 0, 0, -1, 1'b1, nd, nh, hk, to);
        check("abort_hs", nh, 3);
        @(posedge clk); #1;
        i_rst = 1'b1;
        watch_idle(6, ne, nd, nw, nb);
        check("abort_no_done", nd, 0);
        check("abort_idle_wvalid", nw, 0);
        build_payload(0, 8'h00, 8'h00, 0);
        exp_cs = model(16'h0102, 16'h0304, 16'd0, 8'h7F);
        run_frame(16'h0102, 16'h0304, 16'd0, 8'h7F, 0, 0, -1, 1'b0, nd, nh, hk, to);
        check_frame("post_abort", 0, exp_cs, nd, nh, hk, to);

        // Start while busy is ignored; a start right after o_done is taken.
        build_payload(0, 8'h5A, 8'hC3, 4);
        exp_cs = model(16'h4455, 16'h6677, 16'd4, 8'h99);
        run_frame(16'h4455, 16'h6677, 16'd4, 8'h99, 1, 0, 3, 1'b0, nd, nh, hk, to);
        check_frame("busy_start", 4, exp_cs, nd, nh, hk, to);
        build_payload(0, 8'h10, 8'h20, 3);
        exp_cs = model(16'h0001, 16'h0002, 16'd3, 8'h03);
        run_frame(16'h0001, 16'h0002, 16'd3, 8'h03, 0, 0, -1, 1'b0, nd, nh, hk, to);
        check_frame("after_done", 3, exp_cs, nd, nh, hk, to);
        watch_idle(20, ne, nd, nw, nb);
        check("no_second_frame", nw, 0);
        check("no_extra_done", nd, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mhp_tx.md
Name: mhp_tx

Overview:
- Transmit-side MHP frame builder: serialises one complete frame onto the Ethernet write interface.
- Frame byte order: dst[15:8], dst[7:0], src[15:8], src[7:0], size[15:8], size[7:0], dtype, payload bytes, csum[15:8], csum[7:0].
- Header fields come from the user at start. Payload bytes are pulled from a valid/ready byte stream. The 16-bit checksum is generated internally.
- Pairs with the MHP receive/parse logic to give full-duplex frame handling.

Parameters:
MAX_SIZE, 512, largest payload byte count accepted; larger i_size is rejected.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_start  in  1  request to send one frame; sampled only in IDLE
i_dst  in  16  destination MHP address, latched on accepted start
i_src  in  16  source MHP address, latched on accepted start
i_size  in  16  payload byte count, latched on accepted start
i_dtype  in  8  bit7 direction, bits6:0 MHP type, latched on accepted start
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse: frame fully handed off
o_err  out  1  one-cycle pulse: start rejected (i_size > MAX_SIZE)
o_csum  out  16  checksum of the last or current frame
i_pdata  in  8  payload byte
i_pvalid  in  1  payload byte valid
o_pready  out  1  payload byte consumed this cycle when i_pvalid=1
o_wdata  out  8  byte to Ethernet
o_wvalid  out  1  o_wdata valid
i_wready  in  1  Ethernet accepts byte when o_wvalid=1

Behaviour:
- Reset (i_rst=0, async): state=IDLE; all counters and the checksum cleared. Outputs: o_wvalid=0, o_wdata=0, o_busy=0, o_done=0, o_err=0, o_csum=0, o_pready=0.
- Output register:
  - o_wdata/o_wvalid are registered.
  - load_ok = !o_wvalid || i_wready.
  - While o_wvalid=1 and i_wready=0, o_wdata is held stable. No byte is ever dropped or duplicated.
  - If no byte is loaded while load_ok=1, o_wvalid clears next cycle.
- Checksum:
  - 16-bit accumulator, modulo 2^16. Cleared on accepted start.
  - Each header and payload byte is added zero-extended in the cycle it is loaded into the output register.
  - Checksum bytes are not summed. o_csum mirrors the accumulator.
- States:
  - IDLE:
    - o_busy=0.
    - i_start=1 with i_size<=MAX_SIZE: latch fields, clear csum, idx=0, go to HDR, o_busy=1 next cycle.
    - i_start=1 with i_size>MAX_SIZE: pulse o_err, stay IDLE, emit nothing.
  - HDR:
    - On load_ok, load header byte idx (0..6) in the order above, then idx++.
    - After byte 6 is loaded: if size==0, go to CSUM; else go to PAYLOAD with remaining=size.
  - PAYLOAD:
    - o_pready = load_ok && remaining!=0 (combinational through i_wready).
    - On i_pvalid && o_pready: load i_pdata, add it to csum, remaining--.
    - After the last byte, go to CSUM.
    - Payload starvation leaves o_wvalid=0 with no timeout.
  - CSUM:
    - On load_ok, load csum[15:8], then on the next load_ok load csum[7:0].
    - Go to DRAIN.
  - DRAIN:
    - Wait for the handshake (o_wvalid && i_wready) of the final checksum byte.
    - Then pulse o_done for one cycle, o_busy=0, and return to IDLE.
- Latency and framing:
  - First header byte: o_wvalid=1 two cycles after the accepted start edge.
  - Back-to-back frames are allowed: a new start is accepted the cycle after o_done.
  - Total bytes per frame = 9 + size.
- i_start while busy: ignored; latched fields are unchanged.
- Reset mid-frame: immediate abort, partial frame discarded, o_done not pulsed.
- i_pvalid while not in PAYLOAD: o_pready=0, nothing consumed.

Test Plan:
1. Header-only frame: dst=0x0010, src=0x0000, size=0, dtype=0x83, i_wready=1 -> bytes 00 10 00 00 00 00 83 00 93; o_done pulses once; o_csum=0x0093.
2. Payload frame: dst=0x1234, src=0x0001, size=2, dtype=0x01, payload AA 55 -> bytes 12 34 00 01 00 02 01 AA 55 01 49; exactly 2 o_pready&&i_pvalid handshakes.
3. Backpressure: repeat test 2 with i_wready toggled pseudo-randomly, plus a 5-cycle i_pvalid gap mid-payload -> identical byte sequence; o_wdata stable whenever o_wvalid=1 and i_wready=0.
4. Oversize: i_size=MAX_SIZE+1 -> o_err single pulse, o_wvalid stays 0, o_busy stays 0. Then size=MAX_SIZE with all 0xFF payload -> 521 bytes; checksum equals the modulo-2^16 sum (wrap exercised).
5. Reset mid-payload: assert i_rst=0 after 3 payload bytes -> o_wvalid=0 and o_busy=0 immediately, no o_done. A following size=0 frame is emitted correctly.
6. Start while busy: pulse i_start with different fields during a frame -> current frame unchanged, no second frame. A start the cycle after o_done is accepted.
